ps2_rx_frame: RTL

PS/2 device-to-host receiver that sits directly upstream of the arrow-key action decoder.
- Brings the asynchronous ps2_clk/ps2_data lines into the system clock domain and glitch-filters them.
- Deserialises each 11-bit frame and checks the start, odd-parity and stop bits.
- Delivers each validated byte as a one-cycle strobe, so the decoder consumes clean, single-domain byte events instead of sampling raw PS/2 edges.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_filter.sv | 40 ++++
 rtl/ps2_rx_frame.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_CODE_RELEASE  = 8'hF0;
  localparam logic [7:0] PS2_CODE_EXTENDED = 8'hE0;
  localparam int         PS2_DATA_BITS     = 8;

  // A frame is good when data plus parity holds an odd number of ones and the stop bit is high.
  function automatic logic frame_ok(input logic [PS2_DATA_BITS-1:0] data,
                                    input logic parity, input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample debounce for one raw PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;

  // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its neighbour;
  // blocking would collapse the two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_dout <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], din};
      if (r_sync[1] == r_dout) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_dout <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: conditions the raw lines, deserialises 11-bit frames and strobes
// validated bytes. Define PS2_RX_PREFIX_EN to fold 0xE0/0xF0 prefixes into rx_extended/rx_release.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_extended,
  output logic       rx_release,
  output logic       rx_err
);

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_ABORT = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [2:0]       LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic                     w_clk_f;
  logic                     w_data_f;
  logic                     w_fall;
  logic                     r_clk_prev;
  ps2_state_t               r_state;
  logic [2:0]               r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_parity;
  logic [TO_W-1:0]          r_to_cnt;
  logic [7:0]               r_rx_data;
  logic                     r_rx_valid;
  logic                     r_rx_err;
`ifdef PS2_RX_PREFIX_EN
  logic                     r_ext_flag;
  logic                     r_rel_flag;
  logic                     r_rx_extended;
  logic                     r_rx_release;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk),
    .dout (w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_data),
    .dout (w_data_f)
  );

  assign w_fall = r_clk_prev & ~w_clk_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_prev    <= 1'b1;
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_to_cnt      <= '0;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_rx_err      <= 1'b0;
`ifdef PS2_RX_PREFIX_EN
      r_ext_flag    <= 1'b0;
      r_rel_flag    <= 1'b0;
      r_rx_extended <= 1'b0;
      r_rx_release  <= 1'b0;
`endif
    end else begin
      r_clk_prev <= w_clk_f;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
`ifdef PS2_RX_PREFIX_EN
      r_rx_extended <= 1'b0;
      r_rx_release  <= 1'b0;
`endif
      if (r_state == IDLE) begin
        r_to_cnt <= '0;
        if (w_fall && !w_data_f) begin
          r_state   <= DATA;
          r_bit_cnt <= '0;
          r_shift   <= '0;
        end
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          DATA: begin
            r_shift <= {w_data_f, r_shift[PS2_DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) r_state <= PARITY;
            else r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
            r_parity <= w_data_f;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (frame_ok(r_shift, r_parity, w_data_f)) begin
`ifdef PS2_RX_PREFIX_EN
              // Prefix bytes only arm a flag; the following real byte carries them out.
              if (r_shift == PS2_CODE_EXTENDED) begin
                r_ext_flag <= 1'b1;
              end else if (r_shift == PS2_CODE_RELEASE) begin
                r_rel_flag <= 1'b1;
              end else begin
                r_rx_data     <= r_shift;
                r_rx_valid    <= 1'b1;
                r_rx_extended <= r_ext_flag;
                r_rx_release  <= r_rel_flag;
                r_ext_flag    <= 1'b0;
                r_rel_flag    <= 1'b0;
              end
`else
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
`endif
            end else begin
              r_rx_err <= 1'b1;
`ifdef PS2_RX_PREFIX_EN
              r_ext_flag <= 1'b0;
              r_rel_flag <= 1'b0;
`endif
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_to_cnt == TO_ABORT) begin
        // Abort on the edge where the idle count reaches TIMEOUT_CYCLES-1.
        r_state  <= IDLE;
        r_to_cnt <= '0;
        r_rx_err <= 1'b1;
`ifdef PS2_RX_PREFIX_EN
        r_ext_flag <= 1'b0;
        r_rel_flag <= 1'b0;
`endif
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;
`ifdef PS2_RX_PREFIX_EN
  assign rx_extended = r_rx_extended;
  assign rx_release  = r_rx_release;
`else
  assign rx_extended = 1'b0;
  assign rx_release  = 1'b0;
`endif

endmodule
